// File: rtl/cpu_bus.sv
// cpu_bus: CPU address decoder with mirrored work RAM and PPU/PRG request/ack forwarding.
// Build option OPEN_BUS_EN: fallback data comes from an open-bus latch instead of 8'h00.
module cpu_bus #(
    parameter int          RAM_ADDR_BITS  = 11,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic        cpu_write_i,
    input  logic [7:0]  cpu_write_data_i,
    output logic [7:0]  cpu_read_data_o,
    output logic        cpu_read_valid_o,
    output logic [2:0]  ppu_address_o,
    output logic [7:0]  ppu_data_o,
    output logic        ppu_write_o,
    output logic        ppu_request_o,
    input  logic [7:0]  ppu_data_i,
    input  logic        ppu_ack_i,
    output logic [14:0] prg_address_o,
    output logic        prg_request_o,
    input  logic [7:0]  prg_data_i,
    input  logic        prg_ack_i
);
    // state    | meaning
    // IDLE     | waiting for cpu_address_valid_i
    // RAM      | phase 0: RAM access, phase 1: present result
    // EXT_WAIT | PPU/PRG request outstanding, timeout counting
    // DONE     | result valid, held until the CPU request changes
    typedef enum logic [1:0] {IDLE, RAM, EXT_WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 8'd1;

    state_t      state;
    logic [15:0] lat_address;
    logic        lat_write;
    logic [7:0]  lat_wdata;
    logic        ram_phase;
    logic [7:0]  timeout_count;
    logic [7:0]  ram_q;
    logic [7:0]  fallback;
    logic [7:0]  ext_data;
    logic        ext_ack;
    logic [RAM_ADDR_BITS-1:0] ram_index;
    logic [7:0]  ram_mem [0:(1<<RAM_ADDR_BITS)-1];

    assign ram_index = lat_address[RAM_ADDR_BITS-1:0];
    assign ext_data  = lat_address[15] ? prg_data_i : ppu_data_i;
    assign ext_ack   = lat_address[15] ? prg_ack_i  : ppu_ack_i;

    always_ff @(posedge clock_i) begin
        if (state == RAM && !ram_phase) begin
            if (lat_write)
                ram_mem[ram_index] <= lat_wdata;
            ram_q <= ram_mem[ram_index];
        end
    end

`ifdef OPEN_BUS_EN
    logic [7:0] open_bus;

    // CPU write data is captured at accept; read results once they sit on the bus.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            open_bus <= 8'h00;
        else if (state == IDLE && cpu_address_valid_i && cpu_write_i)
            open_bus <= cpu_write_data_i;
        else if (state == DONE && !lat_write)
            open_bus <= cpu_read_data_o;
    end

    assign fallback = open_bus;
`else
    assign fallback = 8'h00;
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state            <= IDLE;
            lat_address      <= 16'h0000;
            lat_write        <= 1'b0;
            lat_wdata        <= 8'h00;
            ram_phase        <= 1'b0;
            timeout_count    <= 8'd0;
            cpu_read_data_o  <= 8'h00;
            cpu_read_valid_o <= 1'b0;
            ppu_address_o    <= 3'd0;
            ppu_data_o       <= 8'h00;
            ppu_write_o      <= 1'b0;
            ppu_request_o    <= 1'b0;
            prg_address_o    <= 15'h0000;
            prg_request_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cpu_address_valid_i) begin
                    lat_address   <= cpu_address_i;
                    lat_write     <= cpu_write_i;
                    lat_wdata     <= cpu_write_data_i;
                    timeout_count <= 8'd0;
                    ram_phase     <= 1'b0;
                    casez (cpu_address_i[15:13])
                        3'b000: state <= RAM;
                        3'b001: begin
                            ppu_address_o <= cpu_address_i[2:0];
                            ppu_data_o    <= cpu_write_data_i;
                            ppu_write_o   <= cpu_write_i;
                            ppu_request_o <= 1'b1;
                            state         <= EXT_WAIT;
                        end
                        3'b1??: begin
                            if (cpu_write_i) begin
                                cpu_read_data_o  <= fallback;
                                cpu_read_valid_o <= 1'b1;
                                state            <= DONE;
                            end else begin
                                prg_address_o <= cpu_address_i[14:0];
                                prg_request_o <= 1'b1;
                                state         <= EXT_WAIT;
                            end
                        end
                        default: begin
                            cpu_read_data_o  <= fallback;
                            cpu_read_valid_o <= 1'b1;
                            state            <= DONE;
                        end
                    endcase
                end
                RAM: begin
                    if (!ram_phase) begin
                        ram_phase <= 1'b1;
                    end else begin
                        cpu_read_data_o  <= lat_write ? lat_wdata : ram_q;
                        cpu_read_valid_o <= 1'b1;
                        ram_phase        <= 1'b0;
                        state            <= DONE;
                    end
                end
                EXT_WAIT: begin
                    if (ext_ack) begin
                        ppu_request_o    <= 1'b0;
                        prg_request_o    <= 1'b0;
                        cpu_read_data_o  <= lat_write ? lat_wdata : ext_data;
                        cpu_read_valid_o <= 1'b1;
                        state            <= DONE;
                    end else if (timeout_count == TIMEOUT_LAST) begin
                        ppu_request_o    <= 1'b0;
                        prg_request_o    <= 1'b0;
                        cpu_read_data_o  <= fallback;
                        cpu_read_valid_o <= 1'b1;
                        state            <= DONE;
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                    end
                end
                DONE: begin
                    if (!cpu_address_valid_i || cpu_address_i != lat_address ||
                        cpu_write_i != lat_write) begin
                        cpu_read_valid_o <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus.sv
// Directed self-checking bench for cpu_bus, built with TIMEOUT_CYCLES=4.
module tb_cpu_bus;
    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [15:0] cpu_address_i;
    logic        cpu_address_valid_i;
    logic        cpu_write_i;
    logic [7:0]  cpu_write_data_i;
    logic [7:0]  cpu_read_data_o;
    logic        cpu_read_valid_o;
    logic [2:0]  ppu_address_o;
    logic [7:0]  ppu_data_o;
    logic        ppu_write_o;
    logic        ppu_request_o;
    logic [7:0]  ppu_data_i;
    logic        ppu_ack_i;
    logic [14:0] prg_address_o;
    logic        prg_request_o;
    logic [7:0]  prg_data_i;
    logic        prg_ack_i;

    int n_cmp = 0;
    int n_err = 0;

`ifdef OPEN_BUS_EN
    localparam logic [7:0] OB_AFTER_42 = 8'h42;
    localparam logic [7:0] OB_AFTER_77 = 8'h77;
`else
    localparam logic [7:0] OB_AFTER_42 = 8'h00;
    localparam logic [7:0] OB_AFTER_77 = 8'h00;
`endif

    cpu_bus #(.RAM_ADDR_BITS(11), .TIMEOUT_CYCLES(8'd4)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i),
        .cpu_address_i(cpu_address_i), .cpu_address_valid_i(cpu_address_valid_i),
        .cpu_write_i(cpu_write_i), .cpu_write_data_i(cpu_write_data_i),
        .cpu_read_data_o(cpu_read_data_o), .cpu_read_valid_o(cpu_read_valid_o),
        .ppu_address_o(ppu_address_o), .ppu_data_o(ppu_data_o),
        .ppu_write_o(ppu_write_o), .ppu_request_o(ppu_request_o),
        .ppu_data_i(ppu_data_i), .ppu_ack_i(ppu_ack_i),
        .prg_address_o(prg_address_o), .prg_request_o(prg_request_o),
        .prg_data_i(prg_data_i), .prg_ack_i(prg_ack_i)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Presents a request and returns just after the accept edge.
    task automatic start(input logic [15:0] a, input logic wr, input logic [7:0] wd);
        cpu_address_i       = a;
        cpu_write_i         = wr;
        cpu_write_data_i    = wd;
        cpu_address_valid_i = 1'b1;
        tick();
    endtask

    task automatic release_bus(input string tag);
        cpu_address_valid_i = 1'b0;
        cpu_write_i         = 1'b0;
        tick();
        check({tag, "_drop_valid"}, cpu_read_valid_o, 1'b0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        cpu_address_i = 16'h0; cpu_address_valid_i = 1'b0; cpu_write_i = 1'b0;
        cpu_write_data_i = 8'h0; ppu_data_i = 8'h0; ppu_ack_i = 1'b0;
        prg_data_i = 8'h0; prg_ack_i = 1'b0;
        #3;
        check("rst_rdata", cpu_read_data_o, 8'h00);
        check("rst_valid", cpu_read_valid_o, 1'b0);
        check("rst_ppu_req", ppu_request_o, 1'b0);
        check("rst_prg_req", prg_request_o, 1'b0);
        check("rst_ppu_addr", ppu_address_o, 3'd0);
        check("rst_prg_addr", prg_address_o, 15'h0);
        #14 reset_n_i = 1'b1;
        tick();

        // Reset vector: ack after 3 clocks
        prg_data_i = 8'h34;
        start(16'hFFFC, 1'b0, 8'h00);
        check("vec_prg_req", prg_request_o, 1'b1);
        check("vec_prg_addr", prg_address_o, 15'h7FFC);
        check("vec_valid_early", cpu_read_valid_o, 1'b0);
        tick();
        tick();
        check("vec_req_held", prg_request_o, 1'b1);
        prg_ack_i = 1'b1;
        tick();
        prg_ack_i = 1'b0;
        check("vec_lo_valid", cpu_read_valid_o, 1'b1);
        check("vec_lo_data", cpu_read_data_o, 8'h34);
        check("vec_req_drop", prg_request_o, 1'b0);
        release_bus("vec_lo");
        prg_data_i = 8'h12;
        start(16'hFFFD, 1'b0, 8'h00);
        prg_ack_i = 1'b1;
        tick();
        prg_ack_i = 1'b0;
        check("vec_hi_valid", cpu_read_valid_o, 1'b1);
        check("vec_hi_data", cpu_read_data_o, 8'h12);
        release_bus("vec_hi");

        // RAM mirror
        start(16'h0005, 1'b1, 8'h42);
        tick();
        tick();
        check("ram_wr_valid", cpu_read_valid_o, 1'b1);
        check("ram_wr_data", cpu_read_data_o, 8'h42);
        release_bus("ram_wr");
        start(16'h0805, 1'b0, 8'h00);
        check("ram_rd_lat0", cpu_read_valid_o, 1'b0);
        tick();
        check("ram_rd_lat1", cpu_read_valid_o, 1'b0);
        tick();
        check("ram_rd_lat2", cpu_read_valid_o, 1'b1);
        check("ram_rd_0805", cpu_read_data_o, 8'h42);
        release_bus("ram_rd1");
        start(16'h1805, 1'b0, 8'h00);
        tick();
        tick();
        check("ram_rd_1805", cpu_read_data_o, 8'h42);
        check("ram_rd_1805_v", cpu_read_valid_o, 1'b1);
        release_bus("ram_rd2");

        // PPU mirror
        ppu_data_i = 8'h80;
        start(16'h3FFA, 1'b0, 8'h00);
        check("ppu_rd_req", ppu_request_o, 1'b1);
        check("ppu_rd_addr", ppu_address_o, 3'd2);
        check("ppu_rd_wr", ppu_write_o, 1'b0);
        ppu_ack_i = 1'b1;
        tick();
        ppu_ack_i = 1'b0;
        check("ppu_rd_data", cpu_read_data_o, 8'h80);
        check("ppu_rd_valid", cpu_read_valid_o, 1'b1);
        check("ppu_rd_req_drop", ppu_request_o, 1'b0);
        tick();
        check("ppu_rd_hold", cpu_read_valid_o, 1'b1);
        release_bus("ppu_rd");
        start(16'h2006, 1'b1, 8'h21);
        check("ppu_wr_addr", ppu_address_o, 3'd6);
        check("ppu_wr_data", ppu_data_o, 8'h21);
        check("ppu_wr_wr", ppu_write_o, 1'b1);
        check("ppu_wr_req", ppu_request_o, 1'b1);
        ppu_ack_i = 1'b1;
        tick();
        ppu_ack_i = 1'b0;
        check("ppu_wr_done", cpu_read_valid_o, 1'b1);
        check("ppu_wr_rdata", cpu_read_data_o, 8'h21);
        release_bus("ppu_wr");

        // Open bus
        start(16'h0005, 1'b0, 8'h00);
        tick();
        tick();
        check("ob_pre_read", cpu_read_data_o, 8'h42);
        release_bus("ob_pre");
        start(16'h5000, 1'b0, 8'h00);
        check("ob_unmapped_v", cpu_read_valid_o, 1'b1);
        check("ob_unmapped_d", cpu_read_data_o, OB_AFTER_42);
        release_bus("ob_unmapped");
        start(16'h9000, 1'b1, 8'h77);
        check("ob_prgwr_noreq", prg_request_o, 1'b0);
        check("ob_prgwr_valid", cpu_read_valid_o, 1'b1);
`ifndef OPEN_BUS_EN
        check("ob_prgwr_data", cpu_read_data_o, 8'h00);
`endif
        release_bus("ob_prgwr");

        // Timeout, no ack
        start(16'h8000, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        check("to_req_c3", prg_request_o, 1'b1);
        check("to_valid_c3", cpu_read_valid_o, 1'b0);
        tick();
        check("to_req_drop", prg_request_o, 1'b0);
        check("to_valid", cpu_read_valid_o, 1'b1);
        check("to_data", cpu_read_data_o, OB_AFTER_77);
        release_bus("to");

        // Ack on the last waiting cycle beats the timeout
        start(16'h8000, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        prg_data_i = 8'h55;
        prg_ack_i  = 1'b1;
        tick();
        prg_ack_i  = 1'b0;
        check("to_ack_valid", cpu_read_valid_o, 1'b1);
        check("to_ack_data", cpu_read_data_o, 8'h55);
        release_bus("to_ack");

        // Reset mid-access
        start(16'h2002, 1'b0, 8'h00);
        tick();
        check("mid_req_before", ppu_request_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        check("mid_ppu_req", ppu_request_o, 1'b0);
        check("mid_prg_req", prg_request_o, 1'b0);
        check("mid_valid", cpu_read_valid_o, 1'b0);
        cpu_address_valid_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        ppu_ack_i = 1'b1;
        ppu_data_i = 8'hAA;
        tick();
        tick();
        ppu_ack_i = 1'b0;
        check("late_ack_valid", cpu_read_valid_o, 1'b0);
        check("late_ack_data", cpu_read_data_o, 8'h00);
        check("late_ack_req", ppu_request_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
